// File: rtl/dram_arb_if.sv
// Requester-side bus of the DRAM arbiter. Each engine drives its own slice of
// the packed command vectors and receives a one-hot grant, a one-hot read-valid
// and the shared read data word.
interface dram_arb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            rd_en;
    logic [NUM_REQ-1:0]            wr_en;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr_rd;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr_wr;
    logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            rvalid;
    logic [DATA_WIDTH-1:0]         rdata;

    // Layer engines drive commands and watch grant / returned data.
    modport master (
        output req, rd_en, wr_en, addr_rd, addr_wr, wdata,
        input  gnt, rvalid, rdata
    );

    // The arbiter consumes commands and produces grant / returned data.
    modport slave (
        input  req, rd_en, wr_en, addr_rd, addr_wr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dram_arb.sv
// Round-robin arbiter for the single DRAM port. One engine holds the grant at a
// time; its commands are forwarded straight to DRAM. Read data is steered back
// to whichever engine issued the read via an owner-tag delay line that matches
// the DRAM read latency, so returns survive a change of grant.
module dram_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int NUM_REQ    = 4,
    parameter int MAX_HOLD   = 16,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    dram_arb_if.slave             bus,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  dram_valid,
    output logic                  dram_en_rd,
    output logic                  dram_en_wr,
    output logic [ADDR_WIDTH-1:0] addr_in,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  err
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                   state_reg, state_next;
    logic [NUM_REQ-1:0]       gnt_reg, gnt_next;
    logic [OW-1:0]            owner_reg, owner_next;
    logic [OW-1:0]            last_owner_reg, last_owner_next;
    logic [CW-1:0]            hold_cnt_reg, hold_cnt_next;
    logic [CW-1:0]            cnt_bumped;
    logic                     beat;
    logic                     others_waiting;
    logic                     pick_found;
    logic [OW-1:0]            pick;
    logic [OW-1:0]            cand;
    logic [RD_LAT-1:0]          tag_valid_reg, tag_valid_next;
    logic [RD_LAT-1:0][OW-1:0]  tag_owner_reg, tag_owner_next;
    logic                     tail_valid;
    logic [OW-1:0]            tail_owner;
    logic [NUM_REQ-1:0]       rvalid_w;

    logic [ADDR_WIDTH-1:0] addr_rd_arr [NUM_REQ];
    logic [ADDR_WIDTH-1:0] addr_wr_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr   [NUM_REQ];

    // Unpack the per-requester slices so the owner can be selected by index.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_rd_arr[gi] = bus.addr_rd[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign addr_wr_arr[gi] = bus.addr_wr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi]   = bus.wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Round-robin pick: first active request after the previous owner, wrapping.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        cand       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = OW'((int'(last_owner_reg) + i) % NUM_REQ);
            if (!pick_found && bus.req[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
        end
    end

    assign beat           = |(gnt_reg & (bus.rd_en | bus.wr_en));
    assign others_waiting = |(bus.req & ~gnt_reg);

    // Beat count including this cycle's command, saturating at the limit.
    // Counting the current beat makes a preempted tenure exactly MAX_HOLD beats.
    always_comb begin
        cnt_bumped = hold_cnt_reg;
        if (beat && (hold_cnt_reg != CW'(MAX_HOLD))) begin
            cnt_bumped = hold_cnt_reg + 1'b1;
        end
    end

    // Grant FSM next state: IDLE picks a winner, GRANT holds until release.
    always_comb begin
        state_next      = state_reg;
        gnt_next        = gnt_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        hold_cnt_next   = hold_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    state_next    = GRANT;
                    gnt_next      = NUM_REQ'(1) << pick;
                    owner_next    = pick;
                    hold_cnt_next = '0;
                end
            end
            GRANT: begin
                hold_cnt_next = cnt_bumped;
                // A release always passes through IDLE, giving one gnt=0 cycle.
                if (!bus.req[owner_reg] ||
                    ((cnt_bumped == CW'(MAX_HOLD)) && others_waiting)) begin
                    state_next      = IDLE;
                    gnt_next        = '0;
                    last_owner_next = owner_reg;
                    hold_cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    // Grant FSM state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            gnt_reg        <= '0;
            owner_reg      <= '0;
            last_owner_reg <= OW'(NUM_REQ - 1);
            hold_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            gnt_reg        <= gnt_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            hold_cnt_reg   <= hold_cnt_next;
        end
    end

    // Forward the owner's command to DRAM; everything reads 0 with no grant.
    always_comb begin
        dram_en_rd = 1'b0;
        dram_en_wr = 1'b0;
        addr_in    = '0;
        addr_out   = '0;
        data_out   = '0;
        if (state_reg == GRANT) begin
            dram_en_rd = bus.rd_en[owner_reg];
            dram_en_wr = bus.wr_en[owner_reg];
            addr_in    = addr_rd_arr[owner_reg];
            addr_out   = addr_wr_arr[owner_reg];
            data_out   = wdata_arr[owner_reg];
        end
    end

    // Tag delay line: stage 0 takes this cycle's read, later stages shift along.
    assign tag_valid_next[0] = dram_en_rd;
    assign tag_owner_next[0] = owner_reg;
    generate
        for (gi = 1; gi < RD_LAT; gi++) begin : g_tag
            assign tag_valid_next[gi] = tag_valid_reg[gi-1];
            assign tag_owner_next[gi] = tag_owner_reg[gi-1];
        end
    endgenerate

    // Tag registers; reset drops every read still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid_reg <= '0;
            tag_owner_reg <= '0;
        end else begin
            tag_valid_reg <= tag_valid_next;
            tag_owner_reg <= tag_owner_next;
        end
    end

    assign tail_valid = tag_valid_reg[RD_LAT-1];
    assign tail_owner = tag_owner_reg[RD_LAT-1];

    // Steer returning data to the issuer recorded in the tail tag.
    always_comb begin
        rvalid_w = '0;
        if (dram_valid && tail_valid) begin
            rvalid_w[tail_owner] = 1'b1;
        end
    end

    assign bus.gnt    = gnt_reg;
    assign bus.rvalid = rvalid_w;
    assign bus.rdata  = data_in;

    assign busy = (|gnt_reg) | (|tag_valid_reg);
    // Commands from non-owners and untagged returns are dropped and flagged.
    assign err  = !rst && ((|((bus.rd_en | bus.wr_en) & ~gnt_reg)) ||
                           (dram_valid && !tail_valid));
endmodule

// File: doc/dram_arb.md
Name: dram_arb

Overview:
Round-robin arbiter sharing the single DRAM read/write port between up to NUM_REQ layer engines (conv, relu, pool, fc, weight prefetch). It grants the port to one requester at a time and forwards that requester's read/write commands to DRAM. Returned read data is routed back to the requester that issued the read, using an owner-tag pipeline. It sits between the layer engines and the DRAM model, replacing the static state-based output mux.

Parameters:
DATA_WIDTH, 32, DRAM data width
ADDR_WIDTH, 18, DRAM address width
NUM_REQ, 4, number of requesters (2..8)
MAX_HOLD, 16, command beats before a holder is preempted while others wait
RD_LAT, 1, cycles from dram_en_rd=1 to matching dram_valid=1 (1..4)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req  in  NUM_REQ  level request per requester; held while it has traffic
rd_en  in  NUM_REQ  read command per requester
wr_en  in  NUM_REQ  write command per requester
addr_rd  in  NUM_REQ*ADDR_WIDTH  packed read addresses, requester i at slice i
addr_wr  in  NUM_REQ*ADDR_WIDTH  packed write addresses
wdata  in  NUM_REQ*DATA_WIDTH  packed write data
gnt  out  NUM_REQ  registered one-hot grant
rvalid  out  NUM_REQ  read data valid, one-hot to the read's issuer
rdata  out  DATA_WIDTH  read data, broadcast to all requesters (equals data_in)
data_in  in  DATA_WIDTH  DRAM read data
dram_valid  in  1  DRAM read data valid
dram_en_rd  out  1  DRAM read enable
dram_en_wr  out  1  DRAM write enable
addr_in  out  ADDR_WIDTH  DRAM read address
addr_out  out  ADDR_WIDTH  DRAM write address
data_out  out  DATA_WIDTH  DRAM write data
busy  out  1  grant held or reads in flight
err  out  1  one-cycle pulse on a protocol violation

Behaviour:
- Reset (async, any time): gnt=0, hold_cnt=0, all tags invalid, last_owner=NUM_REQ-1 (so requester 0 wins first). All DRAM outputs, rvalid and err read 0. In-flight reads are dropped.
- States:
  - IDLE: gnt=0. If any req bit is 1, the next gnt is the first requester with req=1 scanning last_owner+1, last_owner+2, ... with wrap; go to GRANT. Grant appears one cycle after req is seen.
  - GRANT: owner = index of gnt. Each cycle the owner has rd_en or wr_en set counts as one beat; hold_cnt increments, saturating at MAX_HOLD.
  - Release from GRANT to IDLE (gnt=0 next cycle, last_owner=owner, hold_cnt=0) when:
    - req[owner]=0, or
    - hold_cnt==MAX_HOLD and another req bit is 1.
  - Handover therefore always inserts exactly one gnt=0 cycle. If the owner is the only requester, it keeps the grant past MAX_HOLD.
- Forwarding (combinational from the gnt register):
  - dram_en_rd = rd_en[owner]; dram_en_wr = wr_en[owner].
  - addr_in, addr_out and data_out take the owner's slices.
  - When gnt=0, all DRAM outputs are 0.
  - Simultaneous rd and wr in one cycle are both forwarded and count as one beat.
- Read routing:
  - An RD_LAT-deep shift register of {valid, owner_id} is pushed every cycle with {dram_en_rd, owner}.
  - When dram_valid=1 and the tail is valid: rvalid[tail.owner_id]=1 in the same cycle, rdata=data_in.
  - Routing is independent of the current gnt, so reads still return to the issuer after a release.
- busy = (gnt!=0) | any tag valid.
- err pulses for one cycle when either:
  - rd_en or wr_en is set for a requester without the grant (command ignored, not forwarded), or
  - dram_valid=1 with an invalid tail tag (data ignored, no rvalid).
- req dropping in the same cycle as a final command: the command is forwarded, then release occurs.

Test Plan:
- Single requester: req[0]=1, 4 reads at addr 0x10..0x13 with RD_LAT=1 → gnt=0001 one cycle after req; dram_en_rd for 4 cycles; rvalid[0] asserted 1 cycle after each read, rdata matches.
- Round robin: req=1111 held, each requester issues continuous writes, MAX_HOLD=16 → grants in order 0,1,2,3,0; each tenure is exactly 16 beats; one gnt=0 cycle between tenures.
- Read return after handover: req[2] issues a read on its last granted cycle, then drops req; req[3] is pending; RD_LAT=3 → rvalid[2]=1 three cycles later while gnt=0000 or gnt=1000, and rvalid[3] stays 0.
- Violation: gnt=0001 and wr_en[1]=1 → err pulses 1 cycle, dram_en_wr stays 0. Separately, an unsolicited dram_valid → err pulses, rvalid=0.
- Sole requester past MAX_HOLD: req=0001 for 40 beats → gnt stays 0001 with no gap.
- Async reset mid-burst: assert rst with 2 reads in flight (RD_LAT=2) → gnt, DRAM enables and busy go 0 immediately; later dram_valid raises err with no rvalid; after reset, requester 0 wins first.
